// File: rtl/div_issue_ctrl_if.sv
// ============================================================================
// Module   : div_issue_ctrl_if
// Desc     : Request, divider-controller and response signals of div_issue_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_issue_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       start;
  logic [7:0] dividend_q;
  logic [7:0] divisor_q;
  logic       done;
  logic [7:0] rem_hi;
  logic [7:0] rem_lo;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       timeout;

  // Sequencer side
  modport slave (
    input  req_valid, dividend, divisor, done, rem_hi, rem_lo, resp_ready,
    output req_ready, start, dividend_q, divisor_q, resp_valid,
           quotient, remainder, div_by_zero, timeout
  );

  // Requester / divider / consumer side
  modport master (
    output req_valid, dividend, divisor, done, rem_hi, rem_lo, resp_ready,
    input  req_ready, start, dividend_q, divisor_q, resp_valid,
           quotient, remainder, div_by_zero, timeout
  );
endinterface

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// ============================================================================
// Module   : div_issue_ctrl
// Desc     : Issues one 8-bit divide to the divider controller, collects the
//            result and hands it downstream. Optional WAIT watchdog is enabled
//            by defining DIV_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_issue_ctrl #(
  parameter int REM_SHIFT   = 1,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic             clk,
  input  logic             reset,
  div_issue_ctrl_if.slave  bus
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;
  localparam logic [1:0] c_S_RESP  = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  logic       r_start,       w_start_nxt;
  logic       r_resp_valid,  w_resp_valid_nxt;
  logic [7:0] r_quotient,    w_quotient_nxt;
  logic [7:0] r_remainder,   w_remainder_nxt;
  logic       r_div_by_zero, w_div_by_zero_nxt;
  logic       r_timeout,     w_timeout_nxt;
  logic [7:0] r_dividend_q,  w_dividend_q_nxt;
  logic [7:0] r_divisor_q,   w_divisor_q_nxt;

  logic       w_accept;
  logic       w_div_zero;
  logic       w_expired;
  logic [7:0] w_rem_fixed;

  assign bus.req_ready = (r_state == c_S_IDLE);
  assign w_accept      = bus.req_valid && (r_state == c_S_IDLE);
  assign w_div_zero    = (bus.divisor == 8'd0);
  // Restoring division leaves the remainder one position too far left.
  assign w_rem_fixed   = bus.rem_hi >> REM_SHIFT;

`ifdef DIV_TIMEOUT_EN
  localparam int             c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state != c_S_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_expired = (r_state == c_S_WAIT) && (r_wait_cnt == c_CNT_LAST);
`else
  // No watchdog: always false, WAIT holds until done.
  assign w_expired = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_S_IDLE;
      r_start       <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_quotient    <= 8'd0;
      r_remainder   <= 8'd0;
      r_div_by_zero <= 1'b0;
      r_timeout     <= 1'b0;
      r_dividend_q  <= 8'd0;
      r_divisor_q   <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_start       <= w_start_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_quotient    <= w_quotient_nxt;
      r_remainder   <= w_remainder_nxt;
      r_div_by_zero <= w_div_by_zero_nxt;
      r_timeout     <= w_timeout_nxt;
      r_dividend_q  <= w_dividend_q_nxt;
      r_divisor_q   <= w_divisor_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero ? c_S_RESP : c_S_ISSUE;
        end
      end
      c_S_ISSUE: begin
        w_state_nxt = c_S_WAIT;
      end
      c_S_WAIT: begin
        if (bus.done || w_expired) begin
          w_state_nxt = c_S_RESP;
        end
      end
      c_S_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = c_S_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_start_nxt       = 1'b0;
    w_resp_valid_nxt  = r_resp_valid;
    w_quotient_nxt    = r_quotient;
    w_remainder_nxt   = r_remainder;
    w_div_by_zero_nxt = r_div_by_zero;
    w_timeout_nxt     = r_timeout;
    w_dividend_q_nxt  = r_dividend_q;
    w_divisor_q_nxt   = r_divisor_q;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          w_dividend_q_nxt = bus.dividend;
          w_divisor_q_nxt  = bus.divisor;
          if (w_div_zero) begin
            w_resp_valid_nxt  = 1'b1;
            w_quotient_nxt    = 8'hFF;
            w_remainder_nxt   = bus.dividend;
            w_div_by_zero_nxt = 1'b1;
            w_timeout_nxt     = 1'b0;
          end else begin
            w_start_nxt = 1'b1;
          end
        end
      end
      c_S_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle.
        if (bus.done) begin
          w_resp_valid_nxt  = 1'b1;
          w_quotient_nxt    = bus.rem_lo;
          w_remainder_nxt   = w_rem_fixed;
          w_div_by_zero_nxt = 1'b0;
          w_timeout_nxt     = 1'b0;
        end else if (w_expired) begin
          w_resp_valid_nxt  = 1'b1;
          w_quotient_nxt    = 8'd0;
          w_remainder_nxt   = 8'd0;
          w_div_by_zero_nxt = 1'b0;
          w_timeout_nxt     = 1'b1;
        end
      end
      c_S_RESP: begin
        if (bus.resp_ready) begin
          w_resp_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_start_nxt = 1'b0;
      end
    endcase
  end

  assign bus.start       = r_start;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.timeout     = r_timeout;
  assign bus.dividend_q  = r_dividend_q;
  assign bus.divisor_q   = r_divisor_q;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ============================================================================
// Module   : tb_div_issue_ctrl
// Desc     : Randomized scoreboard bench for div_issue_ctrl with a divider model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_issue_ctrl;
  localparam int REM_SHIFT   = 1;
  localparam int TIMEOUT_CYC = 40;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } stim_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  div_issue_ctrl_if bus();

  div_issue_ctrl #(
    .REM_SHIFT   (REM_SHIFT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t  sb[$];
  stim_t stim[$];
  int    n_checks = 0, n_pass = 0;
  int    n_accepted = 0, n_delivered = 0, n_nonzero = 0, n_starts = 0;
  logic  mute = 1'b0, stray = 1'b0, rr_chk_en = 1'b0, model_busy = 1'b0;
  logic [7:0] exp_a = 8'd0, exp_b = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_start"},      bus.start,       0);
    chk({tag, "_resp_valid"}, bus.resp_valid,  0);
    chk({tag, "_quotient"},   bus.quotient,    0);
    chk({tag, "_remainder"},  bus.remainder,   0);
    chk({tag, "_dbz"},        bus.div_by_zero, 0);
    chk({tag, "_timeout"},    bus.timeout,     0);
    chk({tag, "_dividend_q"}, bus.dividend_q,  0);
    chk({tag, "_divisor_q"},  bus.divisor_q,   0);
    chk({tag, "_req_ready"},  bus.req_ready,   1);
  endtask

  // Producer: issues queued operands, records expectations on acceptance.
  initial begin
    logic  last_rr = 1'b0;
    stim_t s;
    exp_t  e;
    bus.req_valid = 1'b0;
    bus.dividend  = 8'd0;
    bus.divisor   = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bus.req_valid = 1'b0;
        last_rr = 1'b0;
        continue;
      end
      if (bus.req_valid && last_rr) begin
        if (bus.divisor == 8'd0) e = '{q: 8'hFF, r: bus.dividend, dbz: 1'b1, to: 1'b0};
        else if (mute)           e = '{q: 8'd0, r: 8'd0, dbz: 1'b0, to: 1'b1};
        else                     e = '{q: bus.dividend / bus.divisor,
                                       r: bus.dividend % bus.divisor, dbz: 1'b0, to: 1'b0};
        sb.push_back(e);
        n_accepted++;
        if (bus.divisor != 8'd0) n_nonzero++;
        exp_a = bus.dividend;
        exp_b = bus.divisor;
        bus.req_valid = 1'b0;
      end
      if (!bus.req_valid && stim.size() > 0 && $urandom_range(0, 2) != 0) begin
        s = stim.pop_front();
        bus.dividend  = s.a;
        bus.divisor   = s.b;
        bus.req_valid = 1'b1;
      end
      last_rr = bus.req_ready;
    end
  end

  // Divider controller/datapath model: restoring layout, remainder pre-shifted.
  initial begin
    int   cnt = 0;
    int   rv;
    logic hang = 1'b0, prev_start = 1'b0, prev_rr = 1'b1;
    logic [7:0] ma = 8'd0, mb = 8'd1;
    bus.done = 1'b0; bus.rem_hi = 8'd0; bus.rem_lo = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        model_busy = 1'b0; bus.done = 1'b0; prev_start = 1'b0; prev_rr = 1'b1;
        continue;
      end
      bus.done = 1'b0;
      if (bus.start) begin
        chk("start_single_cycle", prev_start, 0);
        chk("start_after_accept", prev_rr, 1);
        chk("dividend_q_at_start", bus.dividend_q, exp_a);
        chk("divisor_q_at_start", bus.divisor_q, exp_b);
        n_starts++;
        ma = exp_a; mb = exp_b;
        hang = mute;
        cnt = $urandom_range(1, 6);
        model_busy = 1'b1;
        bus.done = ($urandom_range(0, 3) == 0);
        bus.rem_hi = 8'($urandom); bus.rem_lo = 8'($urandom);
      end else if (model_busy) begin
        if (hang) begin
          if (!mute) model_busy = 1'b0;
        end else begin
          cnt--;
          if (cnt == 0) begin
            chk("dividend_q_held", bus.dividend_q, ma);
            chk("divisor_q_held", bus.divisor_q, mb);
            rv = (int'(ma) % int'(mb)) << REM_SHIFT;
            bus.rem_hi = rv[7:0];
            bus.rem_lo = ma / mb;
            bus.done = 1'b1;
            model_busy = 1'b0;
          end
        end
      end else if (stray || $urandom_range(0, 7) == 0) begin
        bus.done = 1'b1;
        bus.rem_hi = 8'($urandom); bus.rem_lo = 8'($urandom);
        stray = 1'b0;
      end
      prev_start = bus.start;
      prev_rr = bus.req_ready;
    end
  end

  // Monitor/consumer: pops the scoreboard when a response appears.
  initial begin
    exp_t cur = '0;
    logic have_cur = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_done = 1'b0, prev_rr = 1'b1;
    int   hold = 0, last_start = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        have_cur = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_done = 1'b0; prev_rr = 1'b1;
        continue;
      end
      if (prev_v && prev_r) begin
        n_delivered++;
        have_cur = 1'b0;
      end
      if (bus.resp_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", bus.resp_valid, 0);
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            hold = $urandom_range(0, 6);
            if (cur.to)       chk("timeout_latency", cyc - last_start, TIMEOUT_CYC + 1);
            else if (cur.dbz) chk("dbz_latency", prev_rr, 1);
            else              chk("done_to_valid", prev_done, 1);
          end
        end else if (hold > 0) begin
          hold--;
        end
        if (have_cur) begin
          chk("quotient", bus.quotient, cur.q);
          chk("remainder", bus.remainder, cur.r);
          chk("div_by_zero", bus.div_by_zero, cur.dbz);
          chk("timeout", bus.timeout, cur.to);
          chk("req_ready_in_resp", bus.req_ready, 0);
        end
        bus.resp_ready = (hold == 0);
      end else begin
        bus.resp_ready = 1'($urandom_range(0, 1));
      end
      if (bus.start) last_start = cyc;
      prev_v = bus.resp_valid; prev_r = bus.resp_ready;
      prev_done = bus.done;    prev_rr = bus.req_ready;
    end
  end

  // req_ready must be high exactly when nothing is outstanding.
  initial forever begin
    @(posedge clk); #2;
    if (rr_chk_en && !reset) chk("req_ready", bus.req_ready, n_accepted == n_delivered);
  end

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!(stim.size() == 0 && !bus.req_valid && n_accepted == n_delivered) && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk("drain_in_budget", k < budget, 1);
  endtask

  task automatic do_reset_test(input int n);
    int guard = 0;
    mute = 1'b1;
    stim.push_back('{a: 8'd50, b: 8'd5});
    while (!model_busy && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("reach_wait", model_busy, 1);
    repeat (n) begin
      @(posedge clk); #2;
      chk("stall_no_resp", bus.resp_valid, 0);
    end
    @(posedge clk); #3;
    rr_chk_en = 1'b0;
    reset = 1'b1;
    sb.delete();
    n_delivered = n_accepted;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    mute = 1'b0;
    stray = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      chk("stray_done_ignored", bus.resp_valid, 0);
      chk("ready_after_reset", bus.req_ready, 1);
    end
    rr_chk_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    @(negedge clk);
    reset = 1'b0;
    rr_chk_en = 1'b1;

    stim.push_back('{a: 8'd100, b: 8'd7});
    stim.push_back('{a: 8'd55,  b: 8'd0});
    stim.push_back('{a: 8'd200, b: 8'd10});
    stim.push_back('{a: 8'd255, b: 8'd16});
    for (int i = 0; i < 40; i++) begin
      stim_t s;
      s.a = 8'($urandom);
      s.b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 128));
      stim.push_back(s);
    end
    wait_drain(6000);

`ifdef DIV_TIMEOUT_EN
    mute = 1'b1;
    stim.push_back('{a: 8'd77, b: 8'd3});
    wait_drain(300);
    mute = 1'b0;
`else
    do_reset_test(60);
`endif
    do_reset_test(3);

    chk("start_count", n_starts, n_nonzero);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
